// File: rtl/con_bus_ctrl.sv
// con_bus_ctrl: controller for the shared bidirectional lanes between the chip
// and the external host.
//  - RX: captures NB_LANES lane words per host handshake into a one-entry
//    output register that the datapath drains with rx_valid/rx_ready.
//  - TX: packs accumulation results into lane beats, queues them in an output
//    FIFO and drains them to the host, which accepts a beat with con_valid.
//  - Owns bus direction (driving_cons) and inserts TURNAROUND_CYCLES idle
//    cycles with no driver on every direction change.
// Optional build macro CON_BUS_SAT_EN: when defined, each result word is
// saturated to the signed lane range instead of truncated to its low bits.
module con_bus_ctrl #(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int NB_LANES           = 3,
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int OUT_FIFO_DEPTH     = 8,
  parameter int TURNAROUND_CYCLES  = 1
) (
  input  logic                                  clk,
  input  logic                                  arst_n_in,
  input  logic [NB_LANES*IO_DATA_WIDTH-1:0]     con_in,
  output logic [NB_LANES*IO_DATA_WIDTH-1:0]     con_out,
  output logic                                  driving_cons,
  input  logic                                  con_valid,
  output logic                                  con_ready,
  output logic                                  output_valid,
  output logic                                  output_last,
  input  logic                                  tx_mode,
  output logic [NB_LANES*IO_DATA_WIDTH-1:0]     rx_data,
  output logic                                  rx_valid,
  input  logic                                  rx_ready,
  input  logic [ACCUMULATION_WIDTH-1:0]         tx_data,
  input  logic                                  tx_valid,
  input  logic                                  tx_last,
  output logic                                  tx_ready,
  output logic [$clog2(OUT_FIFO_DEPTH):0]       fifo_level
);

  localparam int IW      = IO_DATA_WIDTH;
  localparam int LANES_W = NB_LANES * IO_DATA_WIDTH;
  localparam int AW      = $clog2(OUT_FIFO_DEPTH);
  localparam int PW      = (NB_LANES > 1) ? $clog2(NB_LANES) : 1;
  localparam int TW      = (TURNAROUND_CYCLES > 1) ? $clog2(TURNAROUND_CYCLES) : 1;

  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(OUT_FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_LANE  = PW'(NB_LANES - 1);
  localparam logic [TW-1:0] TURN_LAST  = TW'(TURNAROUND_CYCLES - 1);

  localparam logic [1:0] RX_S      = 2'd0;
  localparam logic [1:0] TURN_TX_S = 2'd1;
  localparam logic [1:0] TX_S      = 2'd2;
  localparam logic [1:0] TURN_RX_S = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [TW-1:0] turn_cnt;
  logic          turn_done;

  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_push;
  logic          fifo_pop;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LANES_W-1:0] mem_data [OUT_FIFO_DEPTH];
  logic               mem_last [OUT_FIFO_DEPTH];

  logic [PW-1:0]      pack_cnt;
  logic [LANES_W-1:0] pack_buf;
  logic [LANES_W-1:0] beat_next;
  logic [IW-1:0]      lane_word;
  logic               tx_accept;
  logic               beat_close;
  logic               rx_capture;

  assign turn_done = (turn_cnt == TURN_LAST);

  // Direction FSM next-state: a tx_mode change is only looked at in RX_S/TX_S,
  // so requests arriving during a turnaround wait until it completes.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    state_nxt = state;
    case (state)
      RX_S:      if (tx_mode)                  state_nxt = TURN_TX_S;
      TURN_TX_S: if (turn_done)                state_nxt = TX_S;
      TX_S:      if (!tx_mode && fifo_empty)   state_nxt = TURN_RX_S;
      TURN_RX_S: if (turn_done)                state_nxt = RX_S;
      default:                                 state_nxt = RX_S;
    endcase
  end

  // Direction FSM state, turnaround counter and registered bus-drive enable.
  always_ff @(posedge clk or negedge arst_n_in) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!arst_n_in) begin
      state        <= RX_S;
      turn_cnt     <= '0;
      driving_cons <= 1'b0;
    end else begin
      state        <= state_nxt;
      driving_cons <= (state_nxt == TX_S);
      if (state_nxt != state)
        turn_cnt <= '0;
      else if (state == TURN_TX_S || state == TURN_RX_S)
        turn_cnt <= turn_cnt + 1'b1;
    end
  end

  // RX handshake: accept new lanes while in RX_S when the holding register is
  // free or being emptied this cycle, which sustains one beat per cycle.
  assign con_ready  = (state == RX_S) && (!rx_valid || rx_ready);
  assign rx_capture = con_valid && con_ready;

  // RX holding register; rx_valid persists across a direction change until consumed.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else if (rx_capture) begin
      rx_valid <= 1'b1;
      rx_data  <= con_in;
    end else if (rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

`ifdef CON_BUS_SAT_EN
  logic [ACCUMULATION_WIDTH-IW:0] word_hi;

  // Saturating conversion: the word fits if all bits from the lane sign bit
  // upward agree; otherwise clamp to the signed lane extreme of its sign.
  always_comb begin
    word_hi   = tx_data[ACCUMULATION_WIDTH-1:IW-1];
    lane_word = tx_data[IW-1:0];
    if (!((&word_hi) || !(|word_hi)))
      lane_word = tx_data[ACCUMULATION_WIDTH-1] ? {1'b1, {(IW-1){1'b0}}}
                                                : {1'b0, {(IW-1){1'b1}}};
  end
`else
  logic unused_tx_hi;

  // Truncating conversion keeps only the low lane bits of the result word.
  assign lane_word    = tx_data[IW-1:0];
  assign unused_tx_hi = ^tx_data[ACCUMULATION_WIDTH-1:IW];
`endif

  assign tx_ready   = !fifo_full;
  assign tx_accept  = tx_valid && tx_ready;
  assign beat_close = (pack_cnt == LAST_LANE) || tx_last;
  assign fifo_push  = tx_accept && beat_close;

  // Beat under construction with the current word in lane pack_cnt; lanes not
  // yet filled read as zero so a tx_last flush pads the beat.
  always_comb begin
    beat_next = '0;
    for (int k = 0; k < NB_LANES; k++) begin
      if (PW'(k) < pack_cnt)
        beat_next[k*IW +: IW] = pack_buf[k*IW +: IW];
      else if (PW'(k) == pack_cnt)
        beat_next[k*IW +: IW] = lane_word;
    end
  end

  // Packing state: lane index and partially filled beat.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      pack_cnt <= '0;
      pack_buf <= '0;
    end else if (tx_accept) begin
      if (beat_close) begin
        pack_cnt <= '0;
        pack_buf <= '0;
      end else begin
        pack_cnt <= pack_cnt + 1'b1;
        pack_buf <= beat_next;
      end
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: FIFO storage has no reset; stale entries are never visible since con_out is gated by output_valid.
    if (fifo_push) begin
      mem_data[wr_ptr] <= beat_next;
      mem_last[wr_ptr] <= tx_last;
    end
  end

  assign fifo_empty   = (fifo_level == '0);
  assign fifo_full    = (fifo_level == FULL_LEVEL);
  assign output_valid = (state == TX_S) && !fifo_empty;
  assign fifo_pop     = output_valid && con_valid;
  assign con_out      = output_valid ? mem_data[rd_ptr] : '0;
  assign output_last  = output_valid && mem_last[rd_ptr];

  // FIFO pointers (wrap naturally, depth is a power of two) and exact occupancy.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

endmodule

// File: tb/tb_con_bus_ctrl.sv
// Self-checking bench for con_bus_ctrl. A queue-based model turns accepted
// result words into expected lane beats and tracks FIFO contents and bus
// direction; outputs are sampled on the falling clock edge.
module tb_con_bus_ctrl;

  localparam int IW    = 16;
  localparam int NL    = 3;
  localparam int ACCW  = 32;
  localparam int DEPTH = 8;
  localparam int TC    = 1;
  localparam int LW    = NL * IW;
  localparam int LVW   = $clog2(DEPTH) + 1;

  logic            clk;
  logic            arst_n_in;
  logic [LW-1:0]   con_in;
  logic [LW-1:0]   con_out;
  logic            driving_cons;
  logic            con_valid;
  logic            con_ready;
  logic            output_valid;
  logic            output_last;
  logic            tx_mode;
  logic [LW-1:0]   rx_data;
  logic            rx_valid;
  logic            rx_ready;
  logic [ACCW-1:0] tx_data;
  logic            tx_valid;
  logic            tx_last;
  logic            tx_ready;
  logic [LVW-1:0]  fifo_level;

  con_bus_ctrl #(
    .IO_DATA_WIDTH      (IW),
    .NB_LANES           (NL),
    .ACCUMULATION_WIDTH (ACCW),
    .OUT_FIFO_DEPTH     (DEPTH),
    .TURNAROUND_CYCLES  (TC)
  ) dut (
    .clk          (clk),
    .arst_n_in    (arst_n_in),
    .con_in       (con_in),
    .con_out      (con_out),
    .driving_cons (driving_cons),
    .con_valid    (con_valid),
    .con_ready    (con_ready),
    .output_valid (output_valid),
    .output_last  (output_last),
    .tx_mode      (tx_mode),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_last      (tx_last),
    .tx_ready     (tx_ready),
    .fifo_level   (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LW-1:0] data;
    logic          last;
  } beat_t;

  int            checks;
  int            errors;
  beat_t         exp_q[$];
  logic [IW-1:0] part_q[$];
  logic          exp_drive;

`ifdef CON_BUS_SAT_EN
  localparam logic [IW-1:0] EXP_POS = 16'h7FFF;
  localparam logic [IW-1:0] EXP_NEG = 16'h8000;
`else
  localparam logic [IW-1:0] EXP_POS = 16'h8000;
  localparam logic [IW-1:0] EXP_NEG = 16'hEE90;
`endif

  // Reference conversion of a signed result word to one lane value.
  function automatic logic [IW-1:0] conv(input logic [ACCW-1:0] w);
    longint v;
    v = longint'($signed(w));
`ifdef CON_BUS_SAT_EN
    if (v > (longint'(1) << (IW-1)) - 1) v = (longint'(1) << (IW-1)) - 1;
    else if (v < -(longint'(1) << (IW-1))) v = -(longint'(1) << (IW-1));
`endif
    return IW'(v);
  endfunction

  function automatic logic [LW-1:0] mk3(input int a, input int b, input int c);
    return {IW'(c), IW'(b), IW'(a)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One TX-side cycle: drive, compare against the model, then advance the model.
  task automatic tx_cycle(input logic [ACCW-1:0] w, input logic v, input logic l, input logic cv);
    int            sz;
    logic          exp_ov;
    logic [LW-1:0] exp_out;
    logic          exp_last;
    logic          acc;
    logic          pop;
    beat_t         b;
    tx_data = w; tx_valid = v; tx_last = l; con_valid = cv;
    @(negedge clk);
    sz       = exp_q.size();
    exp_ov   = exp_drive && (sz > 0);
    exp_out  = '0;
    exp_last = 1'b0;
    if (exp_ov) begin
      exp_out  = exp_q[0].data;
      exp_last = exp_q[0].last;
    end
    checks++; if (tx_ready !== (sz < DEPTH)) begin errors++; $display("FAIL tx_ready: got %0b expected %0b", tx_ready, sz < DEPTH); end
    checks++; if (fifo_level !== LVW'(sz)) begin errors++; $display("FAIL fifo_level: got %0d expected %0d", fifo_level, sz); end
    checks++; if (driving_cons !== exp_drive) begin errors++; $display("FAIL driving_cons: got %0b expected %0b", driving_cons, exp_drive); end
    checks++; if (output_valid !== exp_ov) begin errors++; $display("FAIL output_valid: got %0b expected %0b", output_valid, exp_ov); end
    checks++; if (con_out !== exp_out) begin errors++; $display("FAIL con_out: got %h expected %h", con_out, exp_out); end
    checks++; if (output_last !== exp_last) begin errors++; $display("FAIL output_last: got %0b expected %0b", output_last, exp_last); end
    acc = v && (sz < DEPTH);
    pop = exp_ov && cv;
    if (pop) void'(exp_q.pop_front());
    if (acc) begin
      part_q.push_back(conv(w));
      if (part_q.size() == NL || l) begin
        b.data = '0;
        for (int k = 0; k < part_q.size(); k++) b.data[k*IW +: IW] = part_q[k];
        b.last = l;
        exp_q.push_back(b);
        part_q.delete();
      end
    end
    if (exp_drive && !tx_mode && sz == 0) exp_drive = 1'b0;
    @(posedge clk);
    #1;
    tx_valid = 1'b0; tx_last = 1'b0; con_valid = 1'b0;
  endtask

  // Request transmit and check driving_cons rises TC+1 edges later.
  task automatic enter_tx();
    int n;
    tx_mode = 1'b1;
    n = 0;
    while (!driving_cons && n < 20) begin step(); n++; end
    checks++; if (n != TC + 1) begin errors++; $display("FAIL enter_tx_latency: got %0d expected %0d", n, TC + 1); end
    exp_drive = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (driving_cons !== 1'b0) begin errors++; $display("FAIL rst_driving: got %0b expected 0", driving_cons); end
    checks++; if (con_out !== '0) begin errors++; $display("FAIL rst_con_out: got %h expected 0", con_out); end
    checks++; if (rx_valid !== 1'b0 || rx_data !== '0) begin errors++; $display("FAIL rst_rx: got %0b/%h expected 0/0", rx_valid, rx_data); end
    checks++; if (output_valid !== 1'b0 || output_last !== 1'b0) begin errors++; $display("FAIL rst_out_flags: got %0b/%0b expected 0/0", output_valid, output_last); end
    checks++; if (fifo_level !== '0 || tx_ready !== 1'b1) begin errors++; $display("FAIL rst_fifo: got %0d/%0b expected 0/1", fifo_level, tx_ready); end
    checks++; if (con_ready !== 1'b1) begin errors++; $display("FAIL rst_con_ready: got %0b expected 1", con_ready); end
    @(negedge clk);
    arst_n_in = 1'b1;
    step();
  endtask

  task automatic test_rx();
    rx_ready = 1'b1; con_valid = 1'b1; con_in = mk3(1, 2, 3);
    @(negedge clk);
    checks++; if (con_ready !== 1'b1 || rx_valid !== 1'b0) begin errors++; $display("FAIL rx_c0: got ready %0b valid %0b expected 1/0", con_ready, rx_valid); end
    step();
    con_in = mk3(4, 5, 6);
    @(negedge clk);
    checks++; if (rx_valid !== 1'b1 || rx_data !== mk3(1, 2, 3)) begin errors++; $display("FAIL rx_c1: got %0b/%h expected 1/%h", rx_valid, rx_data, mk3(1, 2, 3)); end
    step();
    con_valid = 1'b0;
    @(negedge clk);
    checks++; if (rx_valid !== 1'b1 || rx_data !== mk3(4, 5, 6)) begin errors++; $display("FAIL rx_c2: got %0b/%h expected 1/%h", rx_valid, rx_data, mk3(4, 5, 6)); end
    step();
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_clear: got %0b expected 0", rx_valid); end
    step();
    rx_ready = 1'b0; con_valid = 1'b1; con_in = mk3(7, 8, 9);
    step();
    con_in = mk3(11, 12, 13);
    @(negedge clk);
    checks++; if (con_ready !== 1'b0 || rx_valid !== 1'b1) begin errors++; $display("FAIL rx_stall: got ready %0b valid %0b expected 0/1", con_ready, rx_valid); end
    step();
    @(negedge clk);
    checks++; if (rx_data !== mk3(7, 8, 9)) begin errors++; $display("FAIL rx_hold: got %h expected %h", rx_data, mk3(7, 8, 9)); end
    step();
    con_valid = 1'b0; rx_ready = 1'b1;
    step();
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_drain: got %0b expected 0", rx_valid); end
    step();
  endtask

  task automatic test_rx_random();
    logic          m_valid;
    logic [LW-1:0] m_data;
    logic          m_ready;
    m_valid = 1'b0; m_data = '0;
    for (int i = 0; i < 60; i++) begin
      con_valid = ($urandom_range(0, 2) != 0);
      rx_ready  = ($urandom_range(0, 2) != 0);
      con_in    = {$urandom(), $urandom()};
      @(negedge clk);
      m_ready = !m_valid || rx_ready;
      checks++; if (con_ready !== m_ready) begin errors++; $display("FAIL rxr_ready: got %0b expected %0b", con_ready, m_ready); end
      checks++; if (rx_valid !== m_valid) begin errors++; $display("FAIL rxr_valid: got %0b expected %0b", rx_valid, m_valid); end
      if (m_valid) begin
        checks++; if (rx_data !== m_data) begin errors++; $display("FAIL rxr_data: got %h expected %h", rx_data, m_data); end
      end
      if (con_valid && m_ready) begin m_valid = 1'b1; m_data = con_in; end
      else if (rx_ready) m_valid = 1'b0;
      step();
    end
    con_valid = 1'b0; rx_ready = 1'b1;
    step();
  endtask

  task automatic test_dir_switch();
    int n;
    rx_ready = 1'b0; con_valid = 1'b1; con_in = mk3(21, 22, 23);
    step();
    con_valid = 1'b0;
    enter_tx();
    checks++; if (rx_valid !== 1'b1 || rx_data !== mk3(21, 22, 23)) begin errors++; $display("FAIL rx_hold_switch: got %0b/%h expected 1/%h", rx_valid, rx_data, mk3(21, 22, 23)); end
    rx_ready = 1'b1;
    step();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_consume_tx: got %0b expected 0", rx_valid); end
    for (int i = 0; i < 6; i++) tx_cycle(100 + i, 1'b1, 1'b0, 1'b0);
    tx_mode = 1'b0;
    tx_cycle('0, 1'b0, 1'b0, 1'b1);
    tx_cycle('0, 1'b0, 1'b0, 1'b1);
    tx_cycle('0, 1'b0, 1'b0, 1'b0);
    checks++; if (driving_cons !== 1'b0 || con_ready !== 1'b0) begin errors++; $display("FAIL turn_rx: got drive %0b ready %0b expected 0/0", driving_cons, con_ready); end
    n = 0;
    while (!con_ready && n < 20) begin step(); n++; end
    checks++; if (n != TC) begin errors++; $display("FAIL turn_rx_len: got %0d expected %0d", n, TC); end
  endtask

  task automatic test_packing();
    tx_cycle(10, 1'b1, 1'b0, 1'b0);
    tx_cycle(20, 1'b1, 1'b0, 1'b0);
    tx_cycle(30, 1'b1, 1'b0, 1'b0);
    tx_cycle(40, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (con_out !== mk3(10, 20, 30) || output_last !== 1'b0) begin errors++; $display("FAIL pack_beat0: got %h/%0b expected %h/0", con_out, output_last, mk3(10, 20, 30)); end
    step();
    tx_cycle('0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (con_out !== mk3(40, 0, 0) || output_last !== 1'b1) begin errors++; $display("FAIL pack_beat1: got %h/%0b expected %h/1", con_out, output_last, mk3(40, 0, 0)); end
    step();
    tx_cycle('0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_conversion();
    tx_cycle(32'h0001_8000, 1'b1, 1'b1, 1'b0);
    tx_cycle(ACCW'(-70000), 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (con_out !== {32'd0, EXP_POS}) begin errors++; $display("FAIL conv_pos: got %h expected %h", con_out, {32'd0, EXP_POS}); end
    step();
    tx_cycle('0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (con_out !== {32'd0, EXP_NEG}) begin errors++; $display("FAIL conv_neg: got %h expected %h", con_out, {32'd0, EXP_NEG}); end
    step();
    tx_cycle('0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < DEPTH * NL; i++) tx_cycle(1000 + i, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (tx_ready !== 1'b0 || fifo_level !== LVW'(DEPTH)) begin errors++; $display("FAIL bp_full: got ready %0b level %0d expected 0/%0d", tx_ready, fifo_level, DEPTH); end
    step();
    tx_cycle(2000, 1'b1, 1'b0, 1'b0);
    tx_cycle(2000, 1'b1, 1'b0, 1'b1);
    tx_cycle(2000, 1'b1, 1'b0, 1'b0);
    tx_cycle(2001, 1'b1, 1'b0, 1'b0);
    tx_cycle(2002, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < NL; i++) tx_cycle(2003 + i, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (fifo_level !== LVW'(DEPTH)) begin errors++; $display("FAIL bp_refill: got %0d expected %0d", fifo_level, DEPTH); end
    step();
    for (int i = 0; i < DEPTH; i++) tx_cycle('0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL bp_drained: got %0d expected 0", fifo_level); end
    step();
  endtask

  task automatic test_random_tx();
    logic [ACCW-1:0] w;
    int              n;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       w = $urandom();
        1:       w = ACCW'(32767 + int'($urandom_range(0, 2)) - 1);
        2:       w = ACCW'(-32768 + int'($urandom_range(0, 2)) - 1);
        default: w = ACCW'($urandom_range(0, 1000));
      endcase
      tx_cycle(w, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0);
    end
    n = 0;
    while (part_q.size() > 0 && n < 40) begin tx_cycle(5, 1'b1, 1'b1, 1'b1); n++; end
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin tx_cycle('0, 1'b0, 1'b0, 1'b1); n++; end
    @(negedge clk);
    checks++; if (fifo_level !== '0 || exp_q.size() != 0) begin errors++; $display("FAIL rnd_drain: got %0d left %0d expected 0/0", fifo_level, exp_q.size()); end
    step();
  endtask

  task automatic test_reset_mid_tx();
    for (int i = 0; i < 10; i++) tx_cycle(300 + i, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (driving_cons !== 1'b1 || fifo_level !== LVW'(3)) begin errors++; $display("FAIL pre_reset: got drive %0b level %0d expected 1/3", driving_cons, fifo_level); end
    #2;
    arst_n_in = 1'b0;
    tx_mode = 1'b0;
    #1;
    checks++; if (driving_cons !== 1'b0 || fifo_level !== '0) begin errors++; $display("FAIL async_reset: got drive %0b level %0d expected 0/0", driving_cons, fifo_level); end
    checks++; if (output_valid !== 1'b0 || con_out !== '0) begin errors++; $display("FAIL async_reset_out: got %0b/%h expected 0/0", output_valid, con_out); end
    exp_q.delete();
    part_q.delete();
    exp_drive = 1'b0;
    @(negedge clk);
    arst_n_in = 1'b1;
    step();
    checks++; if (con_ready !== 1'b1 || driving_cons !== 1'b0) begin errors++; $display("FAIL post_reset_rx: got ready %0b drive %0b expected 1/0", con_ready, driving_cons); end
    enter_tx();
    tx_cycle(55, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (con_out !== mk3(55, 0, 0) || output_last !== 1'b1) begin errors++; $display("FAIL post_reset_pack: got %h/%0b expected %h/1", con_out, output_last, mk3(55, 0, 0)); end
    step();
    tx_cycle('0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    checks = 0; errors = 0; exp_drive = 1'b0;
    arst_n_in = 1'b0; con_in = '0; con_valid = 1'b0; tx_mode = 1'b0;
    rx_ready = 1'b0; tx_data = '0; tx_valid = 1'b0; tx_last = 1'b0;
    test_reset();
    test_rx();
    test_rx_random();
    test_dir_switch();
    enter_tx();
    test_packing();
    test_conversion();
    test_backpressure();
    test_random_tx();
    test_reset_mid_tx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/con_bus_ctrl.md
Name: con_bus_ctrl

Overview:
- Parametrised controller for the shared bidirectional connection lanes between the chip and the external host.
- Receive direction: captures NB_LANES input words per handshake and passes them to the datapath.
- Transmit direction: packs accumulation results into lane beats, buffers them in an output FIFO, and drains them to the host with backpressure.
- Owns bus direction (driving_cons) and inserts turnaround cycles on every direction change.

Parameters:
- IO_DATA_WIDTH, 16, width of one lane
- NB_LANES, 3, number of connection lanes (>=1)
- ACCUMULATION_WIDTH, 32, width of result words from the MAC path
- OUT_FIFO_DEPTH, 8, output FIFO depth in beats (power of 2, >=2)
- TURNAROUND_CYCLES, 1, idle cycles with no driver on direction change (>=1)

Ports:
- clk  in  1  clock
- arst_n_in  in  1  asynchronous reset, active low
- con_in  in  NB_LANES*IO_DATA_WIDTH  sampled lane values; lane k is bits [k*IO_DATA_WIDTH +: IO_DATA_WIDTH]
- con_out  out  NB_LANES*IO_DATA_WIDTH  lane drive values
- driving_cons  out  1  chip drives lanes when 1
- con_valid  in  1  RX: host data valid; TX: host accepts current beat
- con_ready  out  1  RX: chip accepts lanes
- output_valid  out  1  TX beat valid on con_out
- output_last  out  1  current TX beat closes a result group
- tx_mode  in  1  controller request: 1 = transmit, 0 = receive
- rx_data  out  NB_LANES*IO_DATA_WIDTH  captured lanes to datapath
- rx_valid  out  1  rx_data valid
- rx_ready  in  1  datapath consumes rx_data
- tx_data  in  ACCUMULATION_WIDTH  signed result word
- tx_valid  in  1  tx_data valid
- tx_last  in  1  last word of group; flushes a partial beat
- tx_ready  out  1  block accepts tx_data
- fifo_level  out  $clog2(OUT_FIFO_DEPTH)+1  output FIFO occupancy in beats

Behaviour:
- Reset (asynchronous, immediate): state RX_S, driving_cons=0, con_out=0, rx_valid=0, rx_data=0, output_valid=0, output_last=0, FIFO empty, pack counter 0, fifo_level=0.
- FSM states and outputs:
  - RX_S: driving_cons=0.
  - TURN_TX_S: driving_cons=0, waits TURNAROUND_CYCLES cycles.
  - TX_S: driving_cons=1.
  - TURN_RX_S: driving_cons=0, waits TURNAROUND_CYCLES cycles.
- driving_cons is registered and driven directly from state.
- Transitions:
  - RX_S -> TURN_TX_S when tx_mode=1.
  - TURN_TX_S -> TX_S when its counter expires.
  - TX_S -> TURN_RX_S when tx_mode=0 and FIFO empty. With tx_mode=0 and FIFO non-empty, stay in TX_S and keep draining.
  - TURN_RX_S -> RX_S when its counter expires.
  - A tx_mode change during a turnaround is ignored until the turnaround completes.
- RX path:
  - con_ready = (state==RX_S) && (!rx_valid || rx_ready).
  - On con_valid&&con_ready: rx_data<=con_in, rx_valid<=1 next cycle (latency 1).
  - rx_valid clears on rx_ready with no new capture.
  - Back-to-back captures sustain 1 beat/cycle when rx_ready=1.
  - rx_valid holds across the RX->TX switch until consumed.
- Pack path (active in all states):
  - tx_ready = !fifo_full.
  - Each accepted word is converted to IO_DATA_WIDTH (truncation: low bits) and written to lane pack_cnt, then pack_cnt increments.
  - Beat push when pack_cnt==NB_LANES-1 or tx_last: unfilled lanes = 0, beat last flag = tx_last, pack_cnt<=0.
  - tx_ready=0 whenever FIFO full, so a push never overflows.
- TX drain:
  - output_valid = (state==TX_S) && !empty; con_out/output_last = FIFO head.
  - Pop on output_valid&&con_valid.
  - Simultaneous push and pop in one cycle leaves level unchanged.
  - Read/write pointers wrap modulo OUT_FIFO_DEPTH.
  - con_out = 0 when not output_valid.
- fifo_level is registered and exact (0..OUT_FIFO_DEPTH).

Optional Feature:
- Macro CON_BUS_SAT_EN.
- Defined: ACC->lane conversion saturates to signed IO_DATA_WIDTH range, e.g. 16b range [-32768, 32767].
- Undefined: plain truncation to low IO_DATA_WIDTH bits.

Test Plan:
- Reset mid-TX with driving_cons=1 and FIFO level 3 -> driving_cons=0 immediately, fifo_level=0, state RX_S after release.
- RX: host sends lanes {1,2,3} then {4,5,6} back-to-back with rx_ready=1 -> rx_valid on cycles 1-2 with those values; with rx_ready=0, con_ready drops after the first capture.
- Direction switch: tx_mode 0->1 -> driving_cons rises exactly TURNAROUND_CYCLES+1 cycles later; tx_mode 1->0 with 2 beats queued -> driving_cons stays 1 until both popped, then 0.
- Packing: words 10,20,30,40 with tx_last on 40 (NB_LANES=3) -> beats {10,20,30,last=0} and {40,0,0,last=1}.
- Backpressure: fill OUT_FIFO_DEPTH=8 beats with con_valid=0 -> tx_ready=0 and fifo_level=8; one pop plus simultaneous word push -> level stays 8 through the final push, no data lost.
- Word 0x0001_8000 -> lane 0x8000 without CON_BUS_SAT_EN; 0x7FFF with it. Word -70000 -> 0x8000 with CON_BUS_SAT_EN.
